// File: rtl/sin_rcv_pkg.sv
// Shared types and constants for the sine receive monitor and its stimulus.
`timescale 1ns/1ps
package sin_rcv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        MEAS   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam int unsigned CODE_W_DEF = 8;
    typedef logic signed [CODE_W_DEF-1:0] code_t;

    localparam real M_TWO_PI = 6.283185307179586;

    // Largest symmetric code for a signed width w; the most-negative code is never used.
    function automatic int code_max(input int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/sin_quant.sv
// Real-valued sample to saturated, symmetric signed code, registered on clk.
`timescale 1ns/1ps
module sin_quant
    import sin_rcv_pkg::*;
#(
    parameter int unsigned CODE_W     = 8,
    parameter real         FULL_SCALE = 1.0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  real               in,
    output logic [CODE_W-1:0] code
);

    localparam int MAXC = code_max(CODE_W);

    real               scaled_c;
    int                rounded_c;
    logic [CODE_W-1:0] q_c;

    // Round half away from zero, clamp to +/-MAXC.
    always_comb begin
        scaled_c = in / FULL_SCALE * $itor(MAXC);
        if (scaled_c >= $itor(MAXC)) begin
            rounded_c = MAXC;
        end else if (scaled_c <= -$itor(MAXC)) begin
            rounded_c = -MAXC;
        end else if (scaled_c >= 0.0) begin
            rounded_c = $rtoi(scaled_c + 0.5);
        end else begin
            rounded_c = -$rtoi(0.5 - scaled_c);
        end
        q_c = CODE_W'(rounded_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code <= '0;
        end else begin
            code <= q_c;
        end
    end

endmodule

// File: rtl/sin_rcv.sv
// Sine receive monitor: zero-crossing period, peak-to-peak and frequency lock.
// Define SIN_RCV_AMP_EN to build min/max tracking and pk2pk; otherwise pk2pk is 0.
`timescale 1ns/1ps
module sin_rcv
    import sin_rcv_pkg::*;
#(
    parameter int unsigned CODE_W     = 8,
    parameter real         FULL_SCALE = 1.0,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned HYST       = 2,
    parameter int unsigned TOL        = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  real               in,
    input  logic              en,
    output logic [CODE_W-1:0] code,
    output logic [CNT_W-1:0]  period,
    output logic [CODE_W:0]   pk2pk,
    output logic              meas_valid,
    output logic              locked,
    output logic              timeout
);

    localparam logic [CNT_W-1:0]         CNT_MAX  = '1;
    localparam logic signed [CODE_W-1:0] HYST_POS = CODE_W'(HYST);
    localparam logic signed [CODE_W-1:0] HYST_NEG = -HYST_POS;
    localparam logic [CNT_W:0]           TOL_W    = (CNT_W+1)'(TOL);

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt, period_nxt;
    logic                     armed, armed_nxt;
    logic                     prev_valid, prev_valid_nxt;
    logic                     meas_valid_nxt, locked_nxt, timeout_nxt;
    logic signed [CODE_W-1:0] code_s;
    logic signed [CNT_W:0]    diff_c;
    logic [CNT_W:0]           adiff_c;
    logic                     rise_c, in_tol_c, measuring_c, sat_c;

    sin_quant #(
        .CODE_W     (CODE_W),
        .FULL_SCALE (FULL_SCALE)
    ) u_quant (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .code  (code)
    );

    assign code_s      = code;
    assign rise_c      = armed && (code_s >= HYST_POS);
    assign measuring_c = (state == MEAS) || (state == LOCKED);
    assign sat_c       = (cnt == CNT_MAX);
    // Current count against the previous period, one bit wider so it cannot wrap.
    assign diff_c      = $signed({1'b0, cnt}) - $signed({1'b0, period});
    assign adiff_c     = diff_c[CNT_W] ? $unsigned(-diff_c) : $unsigned(diff_c);
    assign in_tol_c    = prev_valid && (adiff_c <= TOL_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ACQ;
                ACQ:     if (rise_c) state_nxt = MEAS;
                MEAS: begin
                    if (rise_c) begin
                        if (in_tol_c) state_nxt = LOCKED;
                    end else if (sat_c) begin
                        state_nxt = ACQ;
                    end
                end
                LOCKED: begin
                    if (rise_c) begin
                        if (!in_tol_c) state_nxt = MEAS;
                    end else if (sat_c) begin
                        state_nxt = ACQ;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values of the counter, crossing arm and registered outputs.
    always_comb begin
        cnt_nxt        = cnt;
        period_nxt     = period;
        armed_nxt      = armed;
        prev_valid_nxt = prev_valid;
        locked_nxt     = locked;
        meas_valid_nxt = 1'b0;
        timeout_nxt    = 1'b0;

        if (!en || rise_c) begin
            armed_nxt = 1'b0;
        end else if (code_s <= HYST_NEG) begin
            armed_nxt = 1'b1;
        end

        if (!en) begin
            cnt_nxt        = '0;
            locked_nxt     = 1'b0;
            prev_valid_nxt = 1'b0;
        end else if ((state == ACQ) && rise_c) begin
            cnt_nxt = CNT_W'(1);
        end else if (measuring_c) begin
            if (rise_c) begin
                period_nxt     = cnt;
                meas_valid_nxt = 1'b1;
                cnt_nxt        = CNT_W'(1);
                prev_valid_nxt = 1'b1;
                locked_nxt     = in_tol_c;
            end else if (sat_c) begin
                timeout_nxt = 1'b1;
                cnt_nxt     = '0;
                locked_nxt  = 1'b0;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            period     <= '0;
            armed      <= 1'b0;
            prev_valid <= 1'b0;
            locked     <= 1'b0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            period     <= period_nxt;
            armed      <= armed_nxt;
            prev_valid <= prev_valid_nxt;
            locked     <= locked_nxt;
            meas_valid <= meas_valid_nxt;
            timeout    <= timeout_nxt;
        end
    end

`ifdef SIN_RCV_AMP_EN
    logic signed [CODE_W-1:0] cmin, cmax;

    // The event sample opens the next window and is excluded from the closing one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmin  <= '0;
            cmax  <= '0;
            pk2pk <= '0;
        end else if (!en) begin
            cmin <= '0;
            cmax <= '0;
        end else if (rise_c && ((state == ACQ) || measuring_c)) begin
            if (measuring_c) begin
                pk2pk <= {cmax[CODE_W-1], cmax} - {cmin[CODE_W-1], cmin};
            end
            cmin <= code_s;
            cmax <= code_s;
        end else if (measuring_c) begin
            if (code_s < cmin) cmin <= code_s;
            if (code_s > cmax) cmax <= code_s;
        end
    end
`else
    assign pk2pk = '0;
`endif

endmodule

// File: tb/tb_sin_rcv.sv
// Directed bench for sin_rcv: quantizer, period/lock, frequency change, timeout, enable and reset.
`timescale 1ns/1ps
module tb_sin_rcv;
    import sin_rcv_pkg::*;

    localparam int unsigned CODE_W = 8;
    localparam int unsigned CNT_W  = 16;

`ifdef SIN_RCV_AMP_EN
    localparam int PK_FULL_LO = 250;
    localparam int PK_FULL_HI = 254;
    localparam int PK_HALF_LO = 125;
    localparam int PK_HALF_HI = 129;
`else
    localparam int PK_FULL_LO = 0;
    localparam int PK_FULL_HI = 0;
    localparam int PK_HALF_LO = 0;
    localparam int PK_HALF_HI = 0;
`endif

    logic              clk;
    logic              rst_n;
    logic              en;
    real               in_val;
    logic [CODE_W-1:0] code;
    logic [CNT_W-1:0]  period;
    logic [CODE_W:0]   pk2pk;
    logic              meas_valid;
    logic              locked;
    logic              timeout;

    int n_checks = 0;
    int n_fail   = 0;

    real               qv [10] = '{2.0, -2.0, 1.0, -1.0, 0.5, -0.5, 0.25, -0.25, 0.004, 0.0};
    logic [CODE_W-1:0] qe [10] = '{8'h7F, 8'h81, 8'h7F, 8'h81, 8'h40, 8'hC0, 8'h20, 8'hE0, 8'h01, 8'h00};

    sin_rcv #(
        .CODE_W     (CODE_W),
        .FULL_SCALE (1.0),
        .CNT_W      (CNT_W),
        .HYST       (2),
        .TOL        (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in_val),
        .en         (en),
        .code       (code),
        .period     (period),
        .pk2pk      (pk2pk),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #0.5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic real wave(input real amp, input int per, input int k);
        return amp * $sin(M_TWO_PI * $itor(k) / $itor(per));
    endfunction

    // Drive one sample, let one posedge take it, return at the following negedge.
    task automatic step(input real v);
        in_val = v;
        @(negedge clk);
    endtask

    task automatic go_idle();
        en = 1'b0;
        step(0.0);
        step(0.0);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        en     = 1'b0;
        in_val = 0.0;
        repeat (3) @(negedge clk);
        n_checks++; if (code !== 8'h00) begin n_fail++; $display("FAIL reset_code: got %0h expected 0", code); end
        n_checks++; if (period !== 16'd0) begin n_fail++; $display("FAIL reset_period: got %0d expected 0", period); end
        n_checks++; if (pk2pk !== 9'd0) begin n_fail++; $display("FAIL reset_pk2pk: got %0d expected 0", pk2pk); end
        n_checks++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL reset_meas_valid: got %b expected 0", meas_valid); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", dut.state); end
        n_checks++; if (dut.cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt); end
        rst_n = 1'b1;
        step(0.0);
    endtask

    task automatic test_quant();
        for (int i = 0; i < 10; i++) begin
            step(qv[i]);
            n_checks++;
            if (code !== qe[i]) begin
                n_fail++;
                $display("FAIL quant_code[%0d]: in %f got %0h expected %0h", i, qv[i], code, qe[i]);
            end
        end
    endtask

    task automatic test_lock();
        int npulse = 0;
        int nto    = 0;
        int exp_idx [3] = '{42, 62, 82};
        logic exp_lck [3] = '{1'b0, 1'b1, 1'b1};
        en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step(wave(1.0, 20, k));
            if (timeout) nto++;
            if (meas_valid) begin
                if (npulse < 3) begin
                    n_checks++; if (k !== exp_idx[npulse]) begin n_fail++; $display("FAIL lock_pulse_time[%0d]: got %0d expected %0d", npulse, k, exp_idx[npulse]); end
                    n_checks++; if (period !== 16'd20) begin n_fail++; $display("FAIL lock_period[%0d]: got %0d expected 20", npulse, period); end
                    n_checks++; if (locked !== exp_lck[npulse]) begin n_fail++; $display("FAIL lock_locked[%0d]: got %b expected %b", npulse, locked, exp_lck[npulse]); end
                    n_checks++; if (int'(pk2pk) < PK_FULL_LO || int'(pk2pk) > PK_FULL_HI) begin n_fail++; $display("FAIL lock_pk2pk[%0d]: got %0d expected %0d..%0d", npulse, pk2pk, PK_FULL_LO, PK_FULL_HI); end
                end
                npulse++;
            end
        end
        n_checks++; if (npulse !== 3) begin n_fail++; $display("FAIL lock_pulse_count: got %0d expected 3", npulse); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_final: got %b expected 1", locked); end
        n_checks++; if (nto !== 0) begin n_fail++; $display("FAIL lock_timeouts: got %0d expected 0", nto); end
    endtask

    task automatic test_en_drop();
        en = 1'b0;
        step(0.0);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL endrop_locked: got %b expected 0", locked); end
        n_checks++; if (period !== 16'd20) begin n_fail++; $display("FAIL endrop_period: got %0d expected 20", period); end
        n_checks++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL endrop_meas_valid: got %b expected 0", meas_valid); end
        n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL endrop_state: got %0d expected IDLE", dut.state); end
        n_checks++; if (int'(pk2pk) < PK_FULL_LO || int'(pk2pk) > PK_FULL_HI) begin n_fail++; $display("FAIL endrop_pk2pk: got %0d expected %0d..%0d", pk2pk, PK_FULL_LO, PK_FULL_HI); end
        step(0.0);
    endtask

    task automatic test_freq_change();
        int npulse = 0;
        int exp_idx [4] = '{102, 142, 182, 222};
        int exp_per [4] = '{20, 40, 40, 40};
        logic exp_lck [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        en = 1'b1;
        for (int k = 0; k < 100; k++) step(wave(1.0, 20, k));
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL freq_prelock: got %b expected 1", locked); end
        for (int k = 100; k < 230; k++) begin
            step(wave(1.0, 40, k - 100));
            if (meas_valid) begin
                if (npulse < 4) begin
                    n_checks++; if (k !== exp_idx[npulse]) begin n_fail++; $display("FAIL freq_pulse_time[%0d]: got %0d expected %0d", npulse, k, exp_idx[npulse]); end
                    n_checks++; if (int'(period) !== exp_per[npulse]) begin n_fail++; $display("FAIL freq_period[%0d]: got %0d expected %0d", npulse, period, exp_per[npulse]); end
                    n_checks++; if (locked !== exp_lck[npulse]) begin n_fail++; $display("FAIL freq_locked[%0d]: got %b expected %b", npulse, locked, exp_lck[npulse]); end
                end
                npulse++;
            end
        end
        n_checks++; if (npulse !== 4) begin n_fail++; $display("FAIL freq_pulse_count: got %0d expected 4", npulse); end
    endtask

    task automatic test_amplitude();
        int npulse = 0;
        int exp_idx [2] = '{42, 62};
        go_idle();
        en = 1'b1;
        for (int k = 0; k < 70; k++) begin
            step(wave(0.5, 20, k));
            if (meas_valid) begin
                if (npulse < 2) begin
                    n_checks++; if (k !== exp_idx[npulse]) begin n_fail++; $display("FAIL amp_pulse_time[%0d]: got %0d expected %0d", npulse, k, exp_idx[npulse]); end
                    n_checks++; if (period !== 16'd20) begin n_fail++; $display("FAIL amp_period[%0d]: got %0d expected 20", npulse, period); end
                    n_checks++; if (int'(pk2pk) < PK_HALF_LO || int'(pk2pk) > PK_HALF_HI) begin n_fail++; $display("FAIL amp_pk2pk[%0d]: got %0d expected %0d..%0d", npulse, pk2pk, PK_HALF_LO, PK_HALF_HI); end
                end
                npulse++;
            end
        end
        n_checks++; if (npulse !== 2) begin n_fail++; $display("FAIL amp_pulse_count: got %0d expected 2", npulse); end
    endtask

    task automatic test_noise();
        int npat [4] = '{1, 0, -1, 0};
        int nmv = 0;
        int nto = 0;
        logic [CODE_W-1:0] exp_c;
        go_idle();
        en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step($itor(npat[i % 4]) / 127.0);
            exp_c = CODE_W'(npat[i % 4]);
            n_checks++; if (code !== exp_c) begin n_fail++; $display("FAIL noise_code[%0d]: got %0h expected %0h", i, code, exp_c); end
            if (meas_valid) nmv++;
            if (timeout) nto++;
        end
        n_checks++; if (nmv !== 0) begin n_fail++; $display("FAIL noise_meas_valid: got %0d expected 0", nmv); end
        n_checks++; if (nto !== 0) begin n_fail++; $display("FAIL noise_timeout: got %0d expected 0", nto); end
        n_checks++; if (dut.state !== ACQ) begin n_fail++; $display("FAIL noise_state: got %0d expected ACQ", dut.state); end
        n_checks++; if (dut.armed !== 1'b0) begin n_fail++; $display("FAIL noise_armed: got %b expected 0", dut.armed); end
    endtask

    task automatic test_timeout();
        int nto = 0;
        int nmv = 0;
        int first_to = -1;
        go_idle();
        en = 1'b1;
        step(-0.5);
        step(0.5);
        for (int i = 2; i < 65546; i++) begin
            step(0.0);
            if (timeout) begin
                nto++;
                if (first_to < 0) first_to = i;
            end
            if (meas_valid) nmv++;
        end
        n_checks++; if (nto !== 1) begin n_fail++; $display("FAIL timeout_count: got %0d expected 1", nto); end
        n_checks++; if (first_to !== 65537) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected 65537", first_to); end
        n_checks++; if (nmv !== 0) begin n_fail++; $display("FAIL timeout_meas_valid: got %0d expected 0", nmv); end
        n_checks++; if (period !== 16'd20) begin n_fail++; $display("FAIL timeout_period: got %0d expected 20", period); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL timeout_locked: got %b expected 0", locked); end
        n_checks++; if (dut.state !== ACQ) begin n_fail++; $display("FAIL timeout_state: got %0d expected ACQ", dut.state); end
        n_checks++; if (dut.cnt !== 16'd0) begin n_fail++; $display("FAIL timeout_cnt: got %0d expected 0", dut.cnt); end
    endtask

    task automatic test_reset_mid();
        go_idle();
        en = 1'b1;
        for (int k = 0; k < 70; k++) step(wave(1.0, 20, k));
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rstmid_prelock: got %b expected 1", locked); end
        #0.2;
        rst_n = 1'b0;
        #0.1;
        n_checks++; if (code !== 8'h00) begin n_fail++; $display("FAIL rstmid_code: got %0h expected 0", code); end
        n_checks++; if (period !== 16'd0) begin n_fail++; $display("FAIL rstmid_period: got %0d expected 0", period); end
        n_checks++; if (pk2pk !== 9'd0) begin n_fail++; $display("FAIL rstmid_pk2pk: got %0d expected 0", pk2pk); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rstmid_locked: got %b expected 0", locked); end
        n_checks++; if (meas_valid !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulses: got %b%b expected 00", meas_valid, timeout); end
        n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d expected IDLE", dut.state); end
        @(negedge clk);
        rst_n = 1'b1;
        step(0.0);
        n_checks++; if (dut.state !== ACQ) begin n_fail++; $display("FAIL rstmid_restart: got %0d expected ACQ", dut.state); end
    endtask

    initial begin
        test_reset();
        test_quant();
        test_lock();
        test_en_drop();
        test_freq_change();
        test_amplitude();
        test_noise();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
